// File: rtl/approx_mult_ctrl_pkg.sv
// Shared definitions for the leading-one approximate multiplier controller:
// state encoding, default phase limits and a small sizing helper.
package approx_mult_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_NORM   = 3'd2,
        ST_MULT   = 3'd3,
        ST_DENORM = 3'd4,
        ST_REWIND = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } ctrl_state_t;

    localparam int DEF_CNT3_MOD   = 8;
    localparam int DEF_NORM_MAX   = 9;
    localparam int DEF_DENORM_MAX = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/approx_mult_ctrl_watchdog.sv
// Phase watchdog: counts enabled cycles since the last clear and flags the
// cycle that would be the limit-th one spent in the current phase.
module cycle_watchdog #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    // The count holds once expired so it can never wrap past the limit.
    assign expired = enable && ((count + W'(1)) == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/approx_mult_ctrl.sv
// Sequencer for the 16x16 leading-one approximate multiplier datapath:
// load, normalize, 8x8 multiply, denormalize, then rewind the 3-bit counter.
module approx_mult_ctrl
    import approx_mult_ctrl_pkg::*;
#(
    parameter int CNT3_MOD   = DEF_CNT3_MOD,
    parameter int NORM_MAX   = DEF_NORM_MAX,
    parameter int DENORM_MAX = DEF_DENORM_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       end_shift1,
    input  logic       end_shift2,
    input  logic       cntr_dual_co,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       load_shift1,
    output logic       load_shift2,
    output logic       sel_sh1,
    output logic       sel_sh2,
    output logic       sel_insh2,
    output logic       en_shift1,
    output logic       en_shift2,
    output logic       cntr_3bit_en,
    output logic       cntr_dual_en,
    output logic       cntr_dual_end,
    output logic [2:0] state_dbg
);

    // Handshake: start is a request sampled only in IDLE; busy covers LOAD
    // through REWIND; done is a one-cycle pulse after which the datapath
    // result is valid until the next LOAD; error is sticky until rst.

    localparam int SH_W  = (CNT3_MOD > 2) ? $clog2(CNT3_MOD) : 1;
    localparam int WD_W  = $clog2(max_int(NORM_MAX, DENORM_MAX) + 1);

    ctrl_state_t     state, state_next;
    logic [SH_W-1:0] shadow, shadow_next, shadow_inc;
    logic            wd_clear, wd_enable, wd_expired;
    logic [WD_W-1:0] wd_limit;

    assign state_dbg  = state;
    assign shadow_inc = (shadow == SH_W'(CNT3_MOD - 1)) ? '0 : shadow + SH_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            shadow <= '0;
        end else begin
            state  <= state_next;
            shadow <= shadow_next;
        end
    end

    always_comb begin
        state_next    = state;
        shadow_next   = shadow;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;
        wd_limit      = WD_W'(DENORM_MAX);
        busy          = 1'b0;
        done          = 1'b0;
        error         = 1'b0;
        load_shift1   = 1'b0;
        load_shift2   = 1'b0;
        sel_sh1       = 1'b0;
        sel_sh2       = 1'b0;
        sel_insh2     = 1'b0;
        en_shift1     = 1'b0;
        en_shift2     = 1'b0;
        cntr_3bit_en  = 1'b0;
        cntr_dual_en  = 1'b0;
        cntr_dual_end = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy        = 1'b1;
                load_shift1 = 1'b1;
                load_shift2 = 1'b1;
                wd_clear    = 1'b1;
                state_next  = ST_NORM;
            end
            ST_NORM: begin
                busy         = 1'b1;
                cntr_3bit_en = 1'b1;
                cntr_dual_en = 1'b1;
                wd_enable    = 1'b1;
                wd_limit     = WD_W'(NORM_MAX);
                shadow_next  = shadow_inc;
                // A normal exit wins over a watchdog expiry in the same cycle.
                if (!end_shift1 && !end_shift2) state_next = ST_MULT;
                else if (wd_expired)            state_next = ST_ERROR;
            end
            ST_MULT: begin
                busy        = 1'b1;
                load_shift1 = 1'b1;
                load_shift2 = 1'b1;
                sel_sh1     = 1'b1;
                sel_sh2     = 1'b1;
                wd_clear    = 1'b1;
                state_next  = ST_DENORM;
            end
            ST_DENORM: begin
                busy      = 1'b1;
                wd_enable = 1'b1;
                if (!cntr_dual_co) begin
                    en_shift1     = 1'b1;
                    en_shift2     = 1'b1;
                    sel_insh2     = 1'b1;
                    cntr_dual_end = 1'b1;
                    if (wd_expired) state_next = ST_ERROR;
                end else begin
                    state_next = (shadow == '0) ? ST_DONE : ST_REWIND;
                end
            end
            ST_REWIND: begin
                busy         = 1'b1;
                cntr_3bit_en = 1'b1;
                shadow_next  = shadow_inc;
                if (shadow_inc == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    cycle_watchdog #(
        .W(WD_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (wd_limit),
        .expired (wd_expired)
    );

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Bench for approx_mult_ctrl: a reactive datapath stub plus a latency and
// pulse-count reference model derived from the operation's phase lengths.
module tb_approx_mult_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       end_shift1, end_shift2, cntr_dual_co;
    logic       busy, done, error, load_shift1, load_shift2, sel_sh1, sel_sh2;
    logic       sel_insh2, en_shift1, en_shift2, cntr_3bit_en, cntr_dual_en, cntr_dual_end;
    logic [2:0] state_dbg;
    logic [12:0] outs;

    int vec = 0;
    int miss = 0;

    int   n1_t = 1, n2_t = 1, d_t = 0;
    logic force_es1 = 1'b0;
    int   rem1, rem2, dcnt;

    always #5 clk = ~clk;

    approx_mult_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .end_shift1(end_shift1), .end_shift2(end_shift2), .cntr_dual_co(cntr_dual_co),
        .busy(busy), .done(done), .error(error),
        .load_shift1(load_shift1), .load_shift2(load_shift2),
        .sel_sh1(sel_sh1), .sel_sh2(sel_sh2), .sel_insh2(sel_insh2),
        .en_shift1(en_shift1), .en_shift2(en_shift2),
        .cntr_3bit_en(cntr_3bit_en), .cntr_dual_en(cntr_dual_en),
        .cntr_dual_end(cntr_dual_end), .state_dbg(state_dbg)
    );

    assign outs = {busy, done, error, load_shift1, load_shift2, sel_sh1, sel_sh2,
                   sel_insh2, en_shift1, en_shift2, cntr_3bit_en, cntr_dual_en, cntr_dual_end};

    // Datapath stub: operand k needs nk-1 self-shifts; the dual counter is
    // loaded with the shift-back amount on the product load.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem1 <= 0;
            rem2 <= 0;
            dcnt <= 0;
        end else begin
            if (load_shift1 && !sel_sh1) begin
                rem1 <= n1_t - 1;
                rem2 <= n2_t - 1;
            end else if (cntr_dual_en) begin
                if (rem1 != 0) rem1 <= rem1 - 1;
                if (rem2 != 0) rem2 <= rem2 - 1;
            end
            if (load_shift1 && sel_sh1) dcnt <= d_t;
            else if (cntr_dual_end && dcnt != 0) dcnt <= dcnt - 1;
        end
    end

    assign end_shift1   = force_es1 || (rem1 != 0);
    assign end_shift2   = (rem2 != 0);
    assign cntr_dual_co = (dcnt == 0);

    function automatic int exp_lat(input int n, input int d);
        int r;
        r = (8 - (n % 8)) % 8;
        return 1 + n + 1 + (d + 1) + r + 1;
    endfunction

    function automatic int exp_rewind(input int n);
        return (8 - (n % 8)) % 8;
    endfunction

    // Runs one operation; counts per-phase pulses and local protocol slips.
    task automatic run_op(input int n1, input int n2, input int d, input bit inject,
                          output int lat, output int n_es, output int n_rw,
                          output int n_dual, output int n_done, output int n_busy,
                          output int bad, output bit tmo);
        n1_t = n1; n2_t = n2; d_t = d;
        lat = 0; n_es = 0; n_rw = 0; n_dual = 0; n_done = 0; n_busy = 0; bad = 0; tmo = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (en_shift1) n_es++;
            if (cntr_3bit_en && !cntr_dual_en) n_rw++;
            if (cntr_dual_en) n_dual++;
            if (busy) n_busy++;
            if (lat == 1 && outs != 13'b1_0_0_1_1_0_0_0_0_0_0_0_0) bad++;
            if (en_shift2 != en_shift1 || sel_insh2 != en_shift1 || cntr_dual_end != en_shift1) bad++;
            if (inject && (lat % 2 == 0) && (cntr_dual_en || cntr_dual_end)) start = 1'b1;
            if (done) begin
                n_done++;
                tmo = 1'b0;
                if (inject) start = 1'b1;
                break;
            end
        end
        if (inject) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) n_done++;
                if (busy) bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vec++;
        if (outs !== 13'd0) begin
            miss++;
            $display("FAIL reset_outputs: got %b, want %b", outs, 13'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (outs !== 13'd0) begin
            miss++;
            $display("FAIL idle_outputs: got %b, want %b", outs, 13'd0);
        end
    endtask

    task automatic test_nominal();
        int lat, n_es, n_rw, n_dual, n_done, n_busy, bad; bit tmo;
        run_op(4, 4, 6, 1'b0, lat, n_es, n_rw, n_dual, n_done, n_busy, bad, tmo);
        vec++; if (tmo)      begin miss++; $display("FAIL nominal_timeout: no done within bound"); end
        vec++; if (lat != 18) begin miss++; $display("FAIL nominal_latency: got %0d, want 18", lat); end
        vec++; if (n_es != 6) begin miss++; $display("FAIL nominal_shifts: got %0d, want 6", n_es); end
        vec++; if (n_rw != 4) begin miss++; $display("FAIL nominal_rewind: got %0d, want 4", n_rw); end
        vec++; if (n_dual != 4) begin miss++; $display("FAIL nominal_norm: got %0d, want 4", n_dual); end
        vec++; if (bad != 0)  begin miss++; $display("FAIL nominal_protocol: got %0d slips, want 0", bad); end
    endtask

    task automatic test_no_shift();
        int lat, n_es, n_rw, n_dual, n_done, n_busy, bad; bit tmo;
        run_op(1, 1, 0, 1'b0, lat, n_es, n_rw, n_dual, n_done, n_busy, bad, tmo);
        vec++; if (lat != 12) begin miss++; $display("FAIL noshift_latency: got %0d, want 12", lat); end
        vec++; if (n_es != 0) begin miss++; $display("FAIL noshift_shifts: got %0d, want 0", n_es); end
        vec++; if (n_rw != 7) begin miss++; $display("FAIL noshift_rewind: got %0d, want 7", n_rw); end
    endtask

    task automatic test_random();
        int lat, n_es, n_rw, n_dual, n_done, n_busy, bad; bit tmo;
        int n1, n2, d, n;
        for (int k = 0; k < 10; k++) begin
            n1 = $urandom_range(9, 1);
            n2 = $urandom_range(9, 1);
            d  = $urandom_range(15, 0);
            if (k == 0) begin n1 = 9; n2 = 8; d = 15; end
            if (k == 1) begin n1 = 3; n2 = 8; d = 2; end
            n = (n1 > n2) ? n1 : n2;
            run_op(n1, n2, d, 1'b0, lat, n_es, n_rw, n_dual, n_done, n_busy, bad, tmo);
            vec++;
            if (lat != exp_lat(n, d)) begin
                miss++; $display("FAIL rand_latency n=%0d d=%0d: got %0d, want %0d", n, d, lat, exp_lat(n, d));
            end
            vec++;
            if (n_es != d || n_dual != n || n_rw != exp_rewind(n)) begin
                miss++;
                $display("FAIL rand_counts n=%0d d=%0d: got es=%0d norm=%0d rw=%0d, want %0d %0d %0d",
                         n, d, n_es, n_dual, n_rw, d, n, exp_rewind(n));
            end
            vec++;
            if (n_busy != exp_lat(n, d) - 1 || bad != 0 || error) begin
                miss++;
                $display("FAIL rand_busy n=%0d d=%0d: got busy=%0d slips=%0d err=%b, want %0d 0 0",
                         n, d, n_busy, bad, error, exp_lat(n, d) - 1);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat, n_es, n_rw, n_dual, n_done, n_busy, bad; bit tmo;
        run_op(5, 2, 7, 1'b1, lat, n_es, n_rw, n_dual, n_done, n_busy, bad, tmo);
        vec++; if (n_done != 1) begin miss++; $display("FAIL ignore_done_count: got %0d, want 1", n_done); end
        vec++; if (lat != exp_lat(5, 7)) begin miss++; $display("FAIL ignore_latency: got %0d, want %0d", lat, exp_lat(5, 7)); end
        vec++; if (bad != 0) begin miss++; $display("FAIL ignore_no_restart: got %0d slips, want 0", bad); end
    endtask

    task automatic test_back_to_back();
        int lat, n_es, n_rw, n_dual, n_done, n_busy, bad; bit tmo;
        run_op(2, 6, 3, 1'b0, lat, n_es, n_rw, n_dual, n_done, n_busy, bad, tmo);
        vec++; if (lat != exp_lat(6, 3)) begin miss++; $display("FAIL b2b_first: got %0d, want %0d", lat, exp_lat(6, 3)); end
        run_op(8, 1, 9, 1'b0, lat, n_es, n_rw, n_dual, n_done, n_busy, bad, tmo);
        vec++; if (lat != exp_lat(8, 9)) begin miss++; $display("FAIL b2b_second: got %0d, want %0d", lat, exp_lat(8, 9)); end
        vec++; if (bad != 0) begin miss++; $display("FAIL b2b_load: got %0d slips, want 0", bad); end
    endtask

    task automatic test_error();
        int n_norm;
        bit seen;
        force_es1 = 1'b1;
        n1_t = 1; n2_t = 1; d_t = 0;
        n_norm = 0; seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (cntr_dual_en) n_norm++;
            if (error) begin seen = 1'b1; break; end
        end
        vec++; if (!seen || n_norm != 9) begin miss++; $display("FAIL err_trap: got seen=%b norm=%0d, want 1 9", seen, n_norm); end
        vec++; if (outs !== 13'b0_0_1_0_0_0_0_0_0_0_0_0_0) begin miss++; $display("FAIL err_outputs: got %b, want %b", outs, 13'b0010000000000); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        vec++; if (error !== 1'b1 || busy !== 1'b0) begin miss++; $display("FAIL err_sticky: got err=%b busy=%b, want 1 0", error, busy); end
        rst = 1'b0;
        force_es1 = 1'b0;
        #1;
        vec++; if (outs !== 13'd0) begin miss++; $display("FAIL err_clear: got %b, want %b", outs, 13'd0); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_async_reset();
        int lat, n_es, n_rw, n_dual, n_done, n_busy, bad; bit tmo;
        bit seen;
        n1_t = 3; n2_t = 2; d_t = 10;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (cntr_dual_end) begin seen = 1'b1; break; end
        end
        #2 rst = 1'b0;
        #1;
        vec++; if (!seen || outs !== 13'd0) begin miss++; $display("FAIL async_rst: got seen=%b outs=%b, want 1 %b", seen, outs, 13'd0); end
        @(negedge clk);
        rst = 1'b1;
        run_op(7, 3, 5, 1'b0, lat, n_es, n_rw, n_dual, n_done, n_busy, bad, tmo);
        vec++; if (lat != exp_lat(7, 5) || n_es != 5) begin miss++; $display("FAIL post_rst_op: got lat=%0d es=%0d, want %0d 5", lat, n_es, exp_lat(7, 5)); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_no_shift();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_error();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
